// File: rtl/run_control_pkg.sv
// Shared types for the run-control block: state encoding and the no-error code.
package runctl_pkg;

  typedef enum logic [2:0] {
    RESET_HOLD = 3'd0,
    RUN        = 3'd1,
    BREAK      = 3'd2,
    HALTED     = 3'd3,
    ERRORED    = 3'd4,
    TIMEOUT    = 3'd5
  } state_t;

  localparam int ERR_NONE = 0;

endpackage

// File: rtl/run_control_if.sv
// CPU-side and supervision signals of run_control; slave = run_control, master = CPU/bench.
interface run_control_if
  import runctl_pkg::*;
#(
  parameter int OPCODE_W = 7,
  parameter int ERR_W    = 2,
  parameter int ADDR_W   = 16,
  parameter int NUM_BP   = 4,
  parameter int CNT_W    = 64
) ();

  logic [OPCODE_W-1:0]      irOpcode;
  logic [ERR_W-1:0]         error;
  logic [ADDR_W-1:0]        pc;
  logic                     atFetch;
  logic [NUM_BP*ADDR_W-1:0] bpAddr;
  logic [NUM_BP-1:0]        bpEnable;
  logic                     resume;
  logic                     cpuEnable;
  logic [CNT_W-1:0]         tickCount;
  state_t                   state;
  logic [ERR_W-1:0]         errorLatched;
  logic [NUM_BP-1:0]        bpHit;
  logic                     dumpStrobe;

  modport master (
    output irOpcode, error, pc, atFetch, bpAddr, bpEnable, resume,
    input  cpuEnable, tickCount, state, errorLatched, bpHit, dumpStrobe
  );

  modport slave (
    input  irOpcode, error, pc, atFetch, bpAddr, bpEnable, resume,
    output cpuEnable, tickCount, state, errorLatched, bpHit, dumpStrobe
  );

endinterface

// File: rtl/run_control_bp_channel.sv
// One breakpoint channel: qualified PC compare plus a mask that blocks re-trigger
// at the same fetch until atFetch is seen low.
module bp_channel #(
  parameter int ADDR_W = 16
) (
  input  logic              clock,
  input  logic              notReset,
  input  logic [ADDR_W-1:0] bp_addr,
  input  logic              bp_en,
  input  logic [ADDR_W-1:0] pc,
  input  logic              at_fetch,
  input  logic              set_mask,
  output logic              match
);

  logic mask_q, mask_d;

  always_comb begin
    mask_d = mask_q;
    if (set_mask) begin
      mask_d = 1'b1;
    end else if (!at_fetch) begin
      mask_d = 1'b0;
    end
  end

  always_ff @(posedge clock or negedge notReset) begin
    if (!notReset) begin
      mask_q <= 1'b0;
    end else begin
      mask_q <= mask_d;
    end
  end

  assign match = at_fetch && bp_en && (pc == bp_addr) && !mask_q;

endmodule

// File: rtl/run_control.sv
// Run-control supervisor: tick counting, CPU clock gating, halt/error/breakpoint stops.
// Optional cycle-limit watchdog enabled by defining RUNCTL_WATCHDOG_EN.
module run_control
  import runctl_pkg::*;
#(
  parameter int                      OPCODE_W    = 7,
  parameter logic [OPCODE_W-1:0]     HALT_OPCODE = OPCODE_W'(7'h7F),
  parameter int                      ERR_W       = 2,
  parameter int                      ADDR_W      = 16,
  parameter int                      NUM_BP      = 4,
  parameter int                      CNT_W       = 64,
  parameter longint unsigned         MAX_CYCLES  = 0
) (
  input logic          clock,
  input logic          notReset,
  run_control_if.slave bus
);

  localparam logic [CNT_W-1:0] WD_LIMIT = CNT_W'(MAX_CYCLES - 1);
`ifdef RUNCTL_WATCHDOG_EN
  localparam bit WD_ON = (MAX_CYCLES != 0);
`else
  localparam bit WD_ON = 1'b0;
`endif

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   tick_q, tick_d;
  logic [ERR_W-1:0]   err_q, err_d;
  logic [NUM_BP-1:0]  bp_hit_q, bp_hit_d;
  logic               dump_q, dump_d;

  logic [NUM_BP-1:0]  bp_match, bp_onehot, set_mask;
  logic               qualified, err_stop, halt_stop, wd_hit;

  for (genvar i = 0; i < NUM_BP; i++) begin : g_bp
    bp_channel #(.ADDR_W(ADDR_W)) u_bp (
      .clock    (clock),
      .notReset (notReset),
      .bp_addr  (bus.bpAddr[i*ADDR_W +: ADDR_W]),
      .bp_en    (bus.bpEnable[i]),
      .pc       (bus.pc),
      .at_fetch (bus.atFetch),
      .set_mask (set_mask[i]),
      .match    (bp_match[i])
    );
  end

  // Isolate the lowest set bit of the match vector.
  assign bp_onehot = bp_match & (~bp_match + NUM_BP'(1));
  assign qualified = (tick_q != '0);
  assign err_stop  = (bus.error != ERR_W'(ERR_NONE));
  assign halt_stop = (bus.irOpcode == HALT_OPCODE);
  assign wd_hit    = WD_ON && (tick_q == WD_LIMIT);

  always_comb begin
    state_d  = state_q;
    tick_d   = tick_q;
    err_d    = err_q;
    bp_hit_d = bp_hit_q;
    dump_d   = 1'b0;
    set_mask = '0;
    case (state_q)
      RESET_HOLD: state_d = RUN;
      RUN: begin
        if (qualified && err_stop) begin
          state_d = ERRORED;
          err_d   = bus.error;
        end else if (qualified && halt_stop) begin
          state_d = HALTED;
          dump_d  = 1'b1;
        end else if (qualified && (bp_match != '0)) begin
          state_d  = BREAK;
          bp_hit_d = bp_onehot;
          set_mask = bp_onehot;
        end else if (qualified && wd_hit) begin
          state_d = TIMEOUT;
        end else if (tick_q != '1) begin
          tick_d = tick_q + CNT_W'(1);
        end
      end
      BREAK: begin
        if (bus.resume) state_d = RUN;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clock or negedge notReset) begin
    if (!notReset) begin
      state_q  <= RESET_HOLD;
      tick_q   <= '0;
      err_q    <= '0;
      bp_hit_q <= '0;
      dump_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      tick_q   <= tick_d;
      err_q    <= err_d;
      bp_hit_q <= bp_hit_d;
      dump_q   <= dump_d;
    end
  end

  assign bus.cpuEnable    = (state_q == RUN);
  assign bus.tickCount    = tick_q;
  assign bus.state        = state_q;
  assign bus.errorLatched = err_q;
  assign bus.bpHit        = bp_hit_q;
  assign bus.dumpStrobe   = dump_q;

endmodule

// File: doc/run_control.md
Name: run_control

Overview:
- Synthesizable run-control and supervision block placed between the system clock and the CPU; it replaces ad-hoc halt/error loops in computer-level benches.
- Counts executed ticks and gates the CPU clock enable.
- Detects the halt opcode, CPU error codes, PC breakpoints and a cycle-limit watchdog.
- Latches the first stop cause and emits a one-cycle memory-dump strobe on halt.

Parameters:
OPCODE_W, 7, width of CPU IR opcode field
HALT_OPCODE, 7'b1111111, opcode value meaning halt
ERR_W, 2, width of CPU error code
ADDR_W, 16, PC/breakpoint address width
NUM_BP, 4, number of breakpoint channels (1..8)
CNT_W, 64, tick counter width
MAX_CYCLES, 0, watchdog limit in ticks; 0 disables

Ports:
clock  in  1  system clock, rising edge
notReset  in  1  asynchronous active-low reset
irOpcode  in  OPCODE_W  current CPU instruction opcode
error  in  ERR_W  CPU error code, 0 = none
pc  in  ADDR_W  CPU program counter
atFetch  in  1  CPU microsequencer is at fetch entry
bpAddr  in  NUM_BP*ADDR_W  breakpoint addresses, channel i at [i*ADDR_W +: ADDR_W]
bpEnable  in  NUM_BP  per-channel breakpoint enable
resume  in  1  one-cycle pulse; leave BREAK
cpuEnable  out  1  CPU clock enable, high only in RUN
tickCount  out  CNT_W  ticks spent in RUN
state  out  3  RESET_HOLD/RUN/BREAK/HALTED/ERRORED/TIMEOUT
errorLatched  out  ERR_W  error code captured at entry to ERRORED
bpHit  out  NUM_BP  one-hot channel that caused the last BREAK
dumpStrobe  out  1  one-cycle pulse on entry to HALTED

Behaviour:
- Reset, asynchronous on notReset low. All outputs take these values:
  - state=RESET_HOLD
  - cpuEnable=0
  - tickCount=0
  - errorLatched=0
  - bpHit=0
  - dumpStrobe=0
- RESET_HOLD -> RUN on the first clock edge after notReset has been sampled high.
- RUN:
  - cpuEnable=1.
  - tickCount increments by 1 per clock and saturates at all-ones (no wrap).
- Stop qualification: stop conditions are evaluated only when tickCount != 0, so stale IR contents during the first tick are ignored.
- Stop causes in RUN, in strict priority order (highest first):
  1. error != 0 -> ERRORED; errorLatched <= error.
  2. irOpcode == HALT_OPCODE -> HALTED; dumpStrobe high for exactly the next cycle.
  3. atFetch && bpEnable[i] && pc == bpAddr[i] for any unmasked i -> BREAK; bpHit <= one-hot of the lowest matching i.
  4. MAX_CYCLES != 0 && tickCount == MAX_CYCLES-1 -> TIMEOUT.
- Transition timing:
  - Each transition takes effect on the same edge that samples the condition.
  - cpuEnable drops combinationally from state, so the CPU receives no further enabled edge.
  - tickCount does not increment on the stopping edge.
- BREAK:
  - resume=1 -> RUN.
  - The hit channel is masked until atFetch is next sampled low, preventing immediate re-trigger at the same fetch.
  - bpHit holds until the next BREAK.
- Resume outside BREAK is ignored.
- HALTED, ERRORED and TIMEOUT are terminal; only reset leaves them.
- Simultaneous error and halt -> ERRORED.
- Simultaneous resume and a new stop condition in BREAK -> stays resumed; conditions are checked from the next RUN cycle.
- Reset mid-run: all state is cleared immediately, regardless of clock.

Optional Feature:
- Macro: RUNCTL_WATCHDOG_EN.
- Defined: MAX_CYCLES watchdog and the TIMEOUT state exist as described.
- Undefined:
  - Watchdog logic is removed.
  - TIMEOUT is unreachable.
  - MAX_CYCLES is ignored.
  - The state encoding is unchanged, so benches decode identically.

Decomposition:
- Package runctl_pkg holds:
  - 3-bit state encodings: RESET_HOLD=0, RUN=1, BREAK=2, HALTED=3, ERRORED=4, TIMEOUT=5.
  - Constant ERR_NONE=0.
- Sub-module bp_channel (one per breakpoint, generate loop). It contains:
  - the address comparator and enable gating;
  - the re-trigger mask flop.
- bp_channel outputs a qualified match bit; a priority encoder in run_control selects the lowest index.

Test Plan:
- Reset released, irOpcode=7'h7F present from time 0 -> no halt at tickCount 0; HALTED entered at tickCount 1; dumpStrobe high exactly 1 cycle; cpuEnable=0.
- error=2'b10 and halt opcode asserted together at tick 20 -> ERRORED, errorLatched=2, tickCount=20, no dumpStrobe.
- bpAddr[1]=16'h0040 enabled, pc reaches 0x0040 with atFetch=1 -> BREAK, bpHit=4'b0010; resume pulse -> RUN; no re-break while atFetch stays high; re-breaks on the next visit to 0x0040.
- Channels 0 and 2 both match the same pc -> bpHit=4'b0001.
- Watchdog, MAX_CYCLES=100, RUNCTL_WATCHDOG_EN defined, no halt -> TIMEOUT with tickCount=99. With the macro undefined -> still RUN at tick 200.
- notReset pulsed low mid-RUN at tick 57, between clock edges -> outputs at reset values immediately; RUN resumes after release with tickCount restarting at 0.
